// File: rtl/ad9280_acq_sequencer.sv
// rtl/ad9280_acq_sequencer.sv - sys-clock acquisition sequencer framing AD9280 core samples into stream packets
module ad9280_acq_sequencer #(
    parameter int MIN_OFF     = 8,
    parameter int FLUSH_QUIET = 16,
    parameter int SWTRIG_LEN  = 4,
    parameter int TMO_W       = 24
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             ctrl_run,
    input  logic             ctrl_single,
    input  logic             ctrl_stop,
    input  logic [15:0]      cfg_frame_len,
    input  logic [15:0]      cfg_holdoff,
    input  logic [TMO_W-1:0] cfg_auto_timeout,
    input  logic             adc_trig_det,
    input  logic             adc_data_valid,
    input  logic [7:0]       adc_data,
    output logic             adc_data_ready,
    output logic             adc_sampling_enable,
    output logic             adc_sw_trigger,
    output logic             m_axis_tvalid,
    output logic [7:0]       m_axis_tdata,
    output logic             m_axis_tlast,
    input  logic             m_axis_tready,
    output logic [2:0]       stat_state,
    output logic             stat_busy,
    output logic             stat_forced,
    output logic             frame_done,
    output logic [15:0]      frame_count
);

    localparam int QW = $clog2(FLUSH_QUIET + 1);
    localparam int SW = $clog2(SWTRIG_LEN + 1);
    localparam logic [TMO_W-1:0] TMO_ONE = TMO_W'(1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FLUSH     = 3'd1,
        S_WAIT_TRIG = 3'd2,
        S_STREAM    = 3'd3,
        S_HOLDOFF   = 3'd4
    } state_e;

    state_e           state_q, state_d;
    logic             trig_s1_q, trig_s2_q, run_prev_q;
    logic             stop_pending_q, stop_pending_d;
    logic             single_mode_q, single_mode_d;
    logic             done_single_q, done_single_d;
    logic [15:0]      state_cnt_q;
    logic [QW-1:0]    quiet_q;
    logic [TMO_W-1:0] tmo_q;
    logic [SW-1:0]    sw_cnt_q;
    logic             sw_fired_q, forced_q;
    logic [15:0]      beats_left_q;
    logic             tvalid_q, tlast_q;
    logic [7:0]       tdata_q;
    logic             frame_done_q;
    logic [15:0]      frame_count_q;

    logic        stop_req, out_free, beat_acc, fire, ready, enable, tlast_hs;
    logic [15:0] eff_holdoff, frame_len_eff;

    // A falling ctrl_run is treated exactly like a ctrl_stop pulse.
    assign stop_req      = ctrl_stop | (run_prev_q & ~ctrl_run);
    assign eff_holdoff   = (cfg_holdoff > 16'(MIN_OFF)) ? cfg_holdoff : 16'(MIN_OFF);
    assign frame_len_eff = (cfg_frame_len == 16'd0) ? 16'd1 : cfg_frame_len;
    assign out_free      = ~tvalid_q | m_axis_tready;
    assign beat_acc      = ready & adc_data_valid &
                           ((state_q == S_WAIT_TRIG) | (state_q == S_STREAM));
    assign fire          = (state_q == S_WAIT_TRIG) & ~trig_s2_q & ~sw_fired_q &
                           (cfg_auto_timeout != '0) & (tmo_q == cfg_auto_timeout - TMO_ONE);
    assign tlast_hs      = tvalid_q & m_axis_tready & tlast_q;

    always_comb begin
        state_d        = state_q;
        stop_pending_d = stop_pending_q;
        single_mode_d  = single_mode_q;
        done_single_d  = done_single_q;
        ready          = 1'b0;
        enable         = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!stop_req && (ctrl_single || ctrl_run)) begin
                    state_d        = S_FLUSH;
                    single_mode_d  = ctrl_single & ~ctrl_run;
                    stop_pending_d = 1'b0;
                    done_single_d  = 1'b0;
                end
            end
            S_FLUSH: begin
                ready = 1'b1;
                if (stop_req) stop_pending_d = 1'b1;
                if ((quiet_q >= QW'(FLUSH_QUIET)) && (state_cnt_q >= 16'(MIN_OFF)))
                    state_d = (stop_pending_q || stop_req || done_single_q) ? S_IDLE : S_WAIT_TRIG;
            end
            S_WAIT_TRIG: begin
                enable = 1'b1;
                if (stop_req) begin
                    stop_pending_d = 1'b1;
                    state_d        = S_FLUSH;
                end else begin
                    ready = (beats_left_q != 16'd0) & out_free;
                    if (ready && adc_data_valid)
                        state_d = (beats_left_q == 16'd1) ? S_HOLDOFF : S_STREAM;
                end
            end
            S_STREAM: begin
                enable = 1'b1;
                ready  = (beats_left_q != 16'd0) & out_free;
                if (stop_req) stop_pending_d = 1'b1;
                if (ready && adc_data_valid && beats_left_q == 16'd1) state_d = S_HOLDOFF;
            end
            S_HOLDOFF: begin
                ready = 1'b1;
                if (stop_req) stop_pending_d = 1'b1;
                if (single_mode_q) done_single_d = 1'b1;
                if (!tvalid_q && state_cnt_q >= eff_holdoff) state_d = S_FLUSH;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q        <= S_IDLE;
            trig_s1_q      <= 1'b0;
            trig_s2_q      <= 1'b0;
            run_prev_q     <= 1'b0;
            stop_pending_q <= 1'b0;
            single_mode_q  <= 1'b0;
            done_single_q  <= 1'b0;
            state_cnt_q    <= 16'd0;
            quiet_q        <= '0;
            tmo_q          <= '0;
            sw_cnt_q       <= '0;
            sw_fired_q     <= 1'b0;
            forced_q       <= 1'b0;
            beats_left_q   <= 16'd0;
            tvalid_q       <= 1'b0;
            tlast_q        <= 1'b0;
            tdata_q        <= 8'd0;
            frame_done_q   <= 1'b0;
            frame_count_q  <= 16'd0;
        end else begin
            state_q        <= state_d;
            trig_s1_q      <= adc_trig_det;
            trig_s2_q      <= trig_s1_q;
            run_prev_q     <= ctrl_run;
            stop_pending_q <= stop_pending_d;
            single_mode_q  <= single_mode_d;
            done_single_q  <= done_single_d;

            if (state_d != state_q) state_cnt_q <= 16'd0;
            else if (state_cnt_q != 16'hFFFF) state_cnt_q <= state_cnt_q + 16'd1;

            if (state_d != state_q || adc_data_valid) quiet_q <= '0;
            else if (quiet_q < QW'(FLUSH_QUIET)) quiet_q <= quiet_q + QW'(1);

            // Timeout only advances while no real trigger is seen, and stops once the forced pulse fired.
            if (state_q != S_WAIT_TRIG) begin
                tmo_q      <= '0;
                sw_fired_q <= 1'b0;
            end else begin
                if (!trig_s2_q && !sw_fired_q) tmo_q <= tmo_q + TMO_ONE;
                if (fire) sw_fired_q <= 1'b1;
            end

            if (fire) sw_cnt_q <= SW'(SWTRIG_LEN);
            else if (sw_cnt_q != '0) sw_cnt_q <= sw_cnt_q - SW'(1);

            if (fire) forced_q <= 1'b1;
            else if (state_d == S_WAIT_TRIG && state_q != S_WAIT_TRIG) forced_q <= 1'b0;

            if (state_d == S_WAIT_TRIG && state_q != S_WAIT_TRIG) beats_left_q <= frame_len_eff;
            else if (beat_acc) beats_left_q <= beats_left_q - 16'd1;

            if (beat_acc) begin
                tvalid_q <= 1'b1;
                tdata_q  <= adc_data;
                tlast_q  <= (beats_left_q == 16'd1);
            end else if (m_axis_tready) begin
                tvalid_q <= 1'b0;
            end

            frame_done_q <= tlast_hs;
            if (tlast_hs) frame_count_q <= frame_count_q + 16'd1;
        end
    end

    assign adc_data_ready      = ready;
    assign adc_sampling_enable = enable;
    assign adc_sw_trigger      = (sw_cnt_q != '0);
    assign m_axis_tvalid       = tvalid_q;
    assign m_axis_tdata        = tdata_q;
    assign m_axis_tlast        = tlast_q;
    assign stat_state          = state_q;
    assign stat_busy           = (state_q != S_IDLE);
    assign stat_forced         = forced_q;
    assign frame_done          = frame_done_q;
    assign frame_count         = frame_count_q;

endmodule

// File: tb/tb_ad9280_acq_sequencer.sv
// tb/tb_ad9280_acq_sequencer.sv - directed self-checking bench for ad9280_acq_sequencer
module tb_ad9280_acq_sequencer;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic        ctrl_run, ctrl_single, ctrl_stop;
    logic [15:0] cfg_frame_len, cfg_holdoff;
    logic [23:0] cfg_auto_timeout;
    logic        adc_trig_det, adc_data_valid;
    logic [7:0]  adc_data;
    logic        adc_data_ready, adc_sampling_enable, adc_sw_trigger;
    logic        m_axis_tvalid, m_axis_tlast, m_axis_tready;
    logic [7:0]  m_axis_tdata;
    logic [2:0]  stat_state;
    logic        stat_busy, stat_forced, frame_done;
    logic [15:0] frame_count;

    always #5 sys_clk = ~sys_clk;

    ad9280_acq_sequencer dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
        .ctrl_run(ctrl_run), .ctrl_single(ctrl_single), .ctrl_stop(ctrl_stop),
        .cfg_frame_len(cfg_frame_len), .cfg_holdoff(cfg_holdoff), .cfg_auto_timeout(cfg_auto_timeout),
        .adc_trig_det(adc_trig_det), .adc_data_valid(adc_data_valid), .adc_data(adc_data),
        .adc_data_ready(adc_data_ready), .adc_sampling_enable(adc_sampling_enable),
        .adc_sw_trigger(adc_sw_trigger),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tdata(m_axis_tdata), .m_axis_tlast(m_axis_tlast),
        .m_axis_tready(m_axis_tready),
        .stat_state(stat_state), .stat_busy(stat_busy), .stat_forced(stat_forced),
        .frame_done(frame_done), .frame_count(frame_count)
    );

    int n_total = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    logic [7:0] src[$];
    logic [7:0] rx_data[$];
    logic       rx_last[$];
    logic       core_en, gate_en;
    int         tr_mode;
    int         fd_cnt, sw_first, sw_hi, wt_idx, lat_viol, stall_viol, en_low, min_gap, busy_ticks;
    logic       prev_stall, prev_last, lat_pend;
    logic [7:0] prev_data, lat_data;
    logic [2:0] prev_state = 3'd0;

    task automatic clear();
        src.delete(); rx_data.delete(); rx_last.delete();
        core_en = 0; gate_en = 1; tr_mode = 0; adc_trig_det = 0;
        fd_cnt = 0; sw_first = -1; sw_hi = 0; wt_idx = 0; lat_viol = 0; stall_viol = 0;
        en_low = 0; min_gap = 1000000; busy_ticks = 0;
        prev_stall = 0; prev_last = 0; prev_data = 0; lat_pend = 0; lat_data = 0;
    endtask

    // One clock: drive core/sink at negedge, observe just after, handshakes complete at next posedge.
    task automatic tick();
        @(negedge sys_clk);
        adc_data_valid = core_en && (src.size() > 0) && (!gate_en || adc_sampling_enable);
        if (adc_data_valid) adc_data = src[0];
        else adc_data = 8'h00;
        case (tr_mode)
            0: m_axis_tready = 1'b1;
            1: m_axis_tready = ~m_axis_tready;
            default: m_axis_tready = 1'b0;
        endcase
        #1;
        if (lat_pend && !(m_axis_tvalid && m_axis_tdata == lat_data)) lat_viol++;
        lat_pend = 0;
        if (prev_stall && !(m_axis_tvalid && m_axis_tdata == prev_data && m_axis_tlast == prev_last))
            stall_viol++;
        prev_stall = m_axis_tvalid && !m_axis_tready;
        prev_data  = m_axis_tdata;
        prev_last  = m_axis_tlast;
        if (m_axis_tvalid && m_axis_tready) begin
            rx_data.push_back(m_axis_tdata);
            rx_last.push_back(m_axis_tlast);
        end
        if (adc_data_valid && adc_data_ready) begin
            if (stat_state == 3'd2 || stat_state == 3'd3) begin
                lat_pend = 1;
                lat_data = adc_data;
            end
            void'(src.pop_front());
        end
        if (frame_done) fd_cnt++;
        if (adc_sw_trigger) sw_hi++;
        if (stat_state == 3'd2) begin
            wt_idx = (prev_state == 3'd2) ? wt_idx + 1 : 0;
            if (adc_sw_trigger && sw_first < 0) sw_first = wt_idx;
        end
        prev_state = stat_state;
        if (adc_sampling_enable) begin
            if (fd_cnt > 0 && en_low > 0 && en_low < min_gap) min_gap = en_low;
            en_low = 0;
        end else begin
            en_low++;
        end
        if (stat_busy) busy_ticks++;
    endtask

    task automatic wait_state(input logic [2:0] s, input int budget, input string tag);
        int n = 0;
        while (stat_state !== s && n < budget) begin
            tick();
            n++;
        end
        chk(tag, 64'(stat_state), 64'(s));
    endtask

    task automatic pulse_single();
        ctrl_single = 1; tick(); ctrl_single = 0;
    endtask

    task automatic chk_outs_zero(input string tag);
        chk(tag, 64'({adc_data_ready, adc_sampling_enable, adc_sw_trigger, m_axis_tvalid, m_axis_tdata,
                      m_axis_tlast, stat_state, stat_busy, stat_forced, frame_done, frame_count}), 64'd0);
    endtask

    task automatic check_rx(input string tag, input logic [7:0] base, input int n, input int flen);
        chk({tag, "_nbeats"}, 64'(rx_data.size()), 64'(n));
        for (int i = 0; i < n && i < rx_data.size(); i++) begin
            logic [7:0] e;
            e = base + 8'(i);
            chk($sformatf("%s_data%0d", tag, i), 64'(rx_data[i]), 64'(e));
            chk($sformatf("%s_last%0d", tag, i), 64'(rx_last[i]), 64'((i % flen) == flen - 1));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        ctrl_run = 0; ctrl_single = 0; ctrl_stop = 0;
        cfg_frame_len = 16'd4; cfg_holdoff = 16'd0; cfg_auto_timeout = 24'd0;
        adc_data_valid = 0; adc_data = 0; m_axis_tready = 0;
        clear();
        repeat (3) tick();
        chk_outs_zero("reset_outs");
        sys_rst_n = 1;
        tick();

        // single frame of 4
        pulse_single();
        chk("t1_flush", 64'(stat_state), 64'd1);
        wait_state(3'd2, 100, "t1_wait_trig");
        adc_trig_det = 1; core_en = 1;
        for (int i = 0; i < 4; i++) src.push_back(8'h10 + 8'(i));
        wait_state(3'd0, 300, "t1_idle");
        check_rx("t1", 8'h10, 4, 4);
        chk("t1_frame_done", 64'(fd_cnt), 64'd1);
        chk("t1_count", 64'(frame_count), 64'd1);
        chk("t1_latency", 64'(lat_viol), 64'd0);
        chk("t1_forced", 64'(stat_forced), 64'd0);
        clear();

        // continuous run, 3 frames of 8, holdoff 20
        cfg_frame_len = 16'd8; cfg_holdoff = 16'd20;
        for (int i = 0; i < 24; i++) src.push_back(8'h20 + 8'(i));
        adc_trig_det = 1; core_en = 1; ctrl_run = 1;
        begin
            int n = 0;
            while (frame_count != 16'd4 && n < 800) begin tick(); n++; end
        end
        chk("t2_count", 64'(frame_count), 64'd4);
        ctrl_run = 0;
        wait_state(3'd0, 200, "t2_idle");
        check_rx("t2", 8'h20, 24, 8);
        chk("t2_frames", 64'(fd_cnt), 64'd3);
        chk("t2_gap_ge_holdoff", 64'(min_gap >= 20 && min_gap < 1000000), 64'd1);
        clear();

        // forced trigger after 100 idle WAIT_TRIG cycles
        cfg_frame_len = 16'd2; cfg_holdoff = 16'd0; cfg_auto_timeout = 24'd100;
        pulse_single();
        wait_state(3'd2, 100, "t3_wait_trig");
        repeat (199) tick();
        chk("t3_swtrig_cycle", 64'(sw_first), 64'd100);
        chk("t3_swtrig_len", 64'(sw_hi), 64'd4);
        chk("t3_forced", 64'(stat_forced), 64'd1);
        src.push_back(8'h31); src.push_back(8'h32); core_en = 1;
        wait_state(3'd0, 200, "t3_idle");
        check_rx("t3", 8'h31, 2, 2);
        chk("t3_forced_sticky", 64'(stat_forced), 64'd1);
        chk("t3_count", 64'(frame_count), 64'd5);
        cfg_auto_timeout = 24'd0;
        clear();

        // sink back-pressure toggling every cycle
        cfg_frame_len = 16'd16;
        for (int i = 0; i < 16; i++) src.push_back(8'h40 + 8'(i));
        adc_trig_det = 1; core_en = 1; tr_mode = 1;
        pulse_single();
        wait_state(3'd0, 400, "t4_idle");
        check_rx("t4", 8'h40, 16, 16);
        chk("t4_stall_stable", 64'(stall_viol), 64'd0);
        chk("t4_latency", 64'(lat_viol), 64'd0);
        chk("t4_count", 64'(frame_count), 64'd6);
        chk("t4_forced_cleared", 64'(stat_forced), 64'd0);
        clear();

        // stop at beat 2 of 8 never truncates the frame
        cfg_frame_len = 16'd8;
        for (int i = 0; i < 8; i++) src.push_back(8'h50 + 8'(i));
        adc_trig_det = 1; core_en = 1; ctrl_run = 1;
        begin
            int n = 0;
            while (rx_data.size() < 2 && n < 200) begin tick(); n++; end
        end
        chk("t5_beat2_seen", 64'(rx_data.size()), 64'd2);
        ctrl_stop = 1; ctrl_run = 0; tick(); ctrl_stop = 0;
        wait_state(3'd0, 200, "t5_idle");
        check_rx("t5", 8'h50, 8, 8);
        chk("t5_count", 64'(frame_count), 64'd7);
        for (int i = 0; i < 4; i++) src.push_back(8'h5A);
        busy_ticks = 0;
        repeat (40) tick();
        chk("t5_no_rearm", 64'(busy_ticks), 64'd0);
        clear();

        // stale beats flushed, frame_len 0 behaves as 1
        cfg_frame_len = 16'd0;
        gate_en = 0; core_en = 1;
        src.push_back(8'hEE); src.push_back(8'hEF); src.push_back(8'hE0);
        pulse_single();
        wait_state(3'd2, 100, "t6_wait_trig");
        chk("t6_stale_drained", 64'(src.size()), 64'd0);
        gate_en = 1; adc_trig_det = 1; src.push_back(8'h66);
        wait_state(3'd0, 200, "t6_idle");
        check_rx("t6", 8'h66, 1, 1);
        chk("t6_count", 64'(frame_count), 64'd8);
        clear();

        // ctrl_stop while waiting for trigger
        cfg_frame_len = 16'd4;
        pulse_single();
        wait_state(3'd2, 100, "t7_wait_trig");
        ctrl_stop = 1; tick(); ctrl_stop = 0;
        chk("t7_to_flush", 64'(stat_state), 64'd1);
        wait_state(3'd0, 100, "t7_idle");
        chk("t7_count", 64'(frame_count), 64'd8);
        chk("t7_no_beats", 64'(rx_data.size()), 64'd0);
        clear();

        // single and stop together in IDLE: stop wins
        ctrl_single = 1; ctrl_stop = 1; tick(); ctrl_single = 0; ctrl_stop = 0;
        repeat (3) tick();
        chk("t8_stay_idle", 64'(stat_state), 64'd0);
        chk("t8_not_busy", 64'(busy_ticks), 64'd0);
        clear();

        // reset in the middle of a stalled frame
        cfg_frame_len = 16'd8;
        for (int i = 0; i < 8; i++) src.push_back(8'h70 + 8'(i));
        adc_trig_det = 1; core_en = 1; tr_mode = 2; ctrl_run = 1;
        wait_state(3'd3, 100, "t9_stream");
        tick();
        chk("t9_tvalid_pre", 64'(m_axis_tvalid), 64'd1);
        sys_rst_n = 0;
        #1;
        chk_outs_zero("t9_reset_outs");
        ctrl_run = 0; core_en = 0;
        repeat (2) tick();
        sys_rst_n = 1;
        repeat (3) tick();
        chk_outs_zero("t9_after_release");

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
